// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: EP6 defaults, packetizer state encoding
// and a counter-width helper. Imported by ep6_packetizer and ep6_byte_counter.
package fx2_pkg;

  localparam int         PKT_BYTES_DEFAULT = 512;
  localparam logic [1:0] EP6_ADDR_DEFAULT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WR_HI,
    ST_WR_LO,
    ST_PKTEND,
    ST_DONE
  } ep6_state_e;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ep6_byte_counter.sv
// EP6 byte-in-packet counter: wraps at PKT_BYTES-1, clears on request.
// Ports: FIFO_CLK, reset (async, high), inc, clr -> next_zero.
module ep6_byte_counter
  import fx2_pkg::*;
#(
  parameter int PKT_BYTES = PKT_BYTES_DEFAULT,
  parameter int W         = cnt_width(PKT_BYTES)
) (
  input  logic FIFO_CLK,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic next_zero
);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;
  logic         at_max;

  assign at_max = (count == W'(PKT_BYTES - 1));

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc) begin
      count_nxt = at_max ? '0 : count + 1'b1;
    end
  end

  // High when the count after this cycle is zero, so the caller can
  // tell on the write edge whether that byte closed a full packet.
  assign next_zero = (count_nxt == '0);

  always_ff @(posedge FIFO_CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/ep6_packetizer.sv
// Serialises 16-bit samples into FX2 EP6 slave-FIFO bytes (high byte first),
// with optional PKTEND commit of short frames (macro EP6_PKTEND_EN).
// Ports: FIFO_CLK, reset (async, high); s_valid/s_ready/s_data/s_last in;
// bus_grant, FIFO6_full in; FIFO_FIFOADR, FIFO_WR, FIFO_DATAOUT,
// FIFO_DATAOUT_OE, FIFO_PKTEND, busy, frame_count out.
module ep6_packetizer
  import fx2_pkg::*;
#(
  parameter int         PKT_BYTES = PKT_BYTES_DEFAULT,
  parameter logic [1:0] EP6_ADDR  = EP6_ADDR_DEFAULT
) (
  input  logic        FIFO_CLK,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  input  logic        bus_grant,
  input  logic        FIFO6_full,
  output logic [1:0]  FIFO_FIFOADR,
  output logic        FIFO_WR,
  output logic [7:0]  FIFO_DATAOUT,
  output logic        FIFO_DATAOUT_OE,
  output logic        FIFO_PKTEND,
  output logic        busy,
  output logic [15:0] frame_count
);

  ep6_state_e  state;
  ep6_state_e  state_nxt;
  logic [15:0] word_q;
  logic        last_q;
  logic        cap;
  logic        wr;
  logic        wr_ok;
  logic        cnt_clr;
  logic        cnt_next_zero;
  logic        frame_inc;

  // Strobes are suppressed while reset is high so the reset cycle is clean.
  assign wr_ok = bus_grant & ~FIFO6_full & ~reset;

  always_comb begin
    state_nxt   = state;
    cap         = 1'b0;
    wr          = 1'b0;
    cnt_clr     = 1'b0;
    frame_inc   = 1'b0;
    FIFO_PKTEND = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s_valid) begin
          cap       = 1'b1;
          state_nxt = ST_TURN;
        end
      end
      ST_TURN: begin
        state_nxt = ST_WR_HI;
      end
      ST_WR_HI: begin
        if (wr_ok) begin
          wr        = 1'b1;
          state_nxt = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        if (wr_ok) begin
          wr = 1'b1;
          if (!last_q) begin
            state_nxt = ST_IDLE;
          end
`ifdef EP6_PKTEND_EN
          else if (!cnt_next_zero) begin
            state_nxt = ST_PKTEND;
          end
`endif
          else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PKTEND: begin
`ifdef EP6_PKTEND_EN
        if (wr_ok) begin
          FIFO_PKTEND = 1'b1;
          cnt_clr     = 1'b1;
          state_nxt   = ST_DONE;
        end
`else
        state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        frame_inc = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifndef EP6_PKTEND_EN
  // Without PKTEND commits the packet fill level never steers the FSM.
  logic next_zero_unused;
  assign next_zero_unused = cnt_next_zero;
`endif

  always_ff @(posedge FIFO_CLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      word_q      <= '0;
      last_q      <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        word_q <= s_data;
        last_q <= s_last;
      end
      if (frame_inc) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  ep6_byte_counter #(
    .PKT_BYTES (PKT_BYTES)
  ) u_cnt (
    .FIFO_CLK  (FIFO_CLK),
    .reset     (reset),
    .inc       (wr),
    .clr       (cnt_clr),
    .next_zero (cnt_next_zero)
  );

  assign s_ready         = (state == ST_IDLE) & ~reset;
  assign busy            = (state != ST_IDLE);
  assign FIFO_WR         = wr;
  assign FIFO_DATAOUT_OE = wr;
  assign FIFO_FIFOADR    = (state == ST_IDLE) ? 2'b00 : EP6_ADDR;

  always_comb begin
    FIFO_DATAOUT = 8'h00;
    if (state == ST_WR_HI) begin
      FIFO_DATAOUT = word_q[15:8];
    end else if (state == ST_WR_LO) begin
      FIFO_DATAOUT = word_q[7:0];
    end
  end

endmodule

// File: tb/tb_ep6_packetizer.sv
// Directed self-checking bench for ep6_packetizer.
// Works in both builds (EP6_PKTEND_EN defined or not).
module tb_ep6_packetizer;

  logic        FIFO_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        bus_grant = 1'b1;
  logic        FIFO6_full = 1'b0;
  logic [1:0]  FIFO_FIFOADR;
  logic        FIFO_WR;
  logic [7:0]  FIFO_DATAOUT;
  logic        FIFO_DATAOUT_OE;
  logic        FIFO_PKTEND;
  logic        busy;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] wq[$];
  int pk = 0;

  ep6_packetizer dut (
    .FIFO_CLK        (FIFO_CLK),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .bus_grant       (bus_grant),
    .FIFO6_full      (FIFO6_full),
    .FIFO_FIFOADR    (FIFO_FIFOADR),
    .FIFO_WR         (FIFO_WR),
    .FIFO_DATAOUT    (FIFO_DATAOUT),
    .FIFO_DATAOUT_OE (FIFO_DATAOUT_OE),
    .FIFO_PKTEND     (FIFO_PKTEND),
    .busy            (busy),
    .frame_count     (frame_count)
  );

  always #5 FIFO_CLK = ~FIFO_CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes and PKTEND strobes as the FX2 would see them on the next edge.
  always @(negedge FIFO_CLK) begin
    if (!reset) begin
      if (FIFO_WR) wq.push_back(FIFO_DATAOUT);
      if (FIFO_PKTEND) pk++;
    end
    chk("oe_without_grant", {31'd0, FIFO_DATAOUT_OE & ~bus_grant}, 0);
  end

  task automatic step();
    @(posedge FIFO_CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'd0, s_ready}, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_cnt.count);
  endfunction

  initial begin
    // Reset state
    step();
    step();
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_wr", {31'd0, FIFO_WR}, 0);
    chk("rst_oe", {31'd0, FIFO_DATAOUT_OE}, 0);
    chk("rst_pktend", {31'd0, FIFO_PKTEND}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {24'd0, FIFO_DATAOUT}, 0);
    chk("rst_addr", {30'd0, FIFO_FIFOADR}, 0);
    chk("rst_frames", {16'd0, frame_count}, 0);
    chk("rst_cnt", cnt(), 0);
    reset = 1'b0;
    step();
    chk("idle_ready", {31'd0, s_ready}, 1);

    // One short frame: A5, 5A back to back
    wq.delete();
    pk = 0;
    send(16'hA55A, 1'b1);
    chk("turn_busy", {31'd0, busy}, 1);
    chk("turn_addr", {30'd0, FIFO_FIFOADR}, 2);
    chk("turn_wr", {31'd0, FIFO_WR}, 0);
    chk("turn_oe", {31'd0, FIFO_DATAOUT_OE}, 0);
    step();
    chk("hi_wr", {31'd0, FIFO_WR}, 1);
    chk("hi_oe", {31'd0, FIFO_DATAOUT_OE}, 1);
    chk("hi_data", {24'd0, FIFO_DATAOUT}, 32'hA5);
    step();
    chk("lo_wr", {31'd0, FIFO_WR}, 1);
    chk("lo_data", {24'd0, FIFO_DATAOUT}, 32'h5A);
    step();
`ifdef EP6_PKTEND_EN
    chk("pktend_pulse", {31'd0, FIFO_PKTEND}, 1);
    chk("pktend_nowr", {31'd0, FIFO_WR}, 0);
    step();
`endif
    chk("done_pktend", {31'd0, FIFO_PKTEND}, 0);
    chk("done_busy", {31'd0, busy}, 1);
    step();
    chk("f1_idle", {31'd0, busy}, 0);
    chk("f1_frames", {16'd0, frame_count}, 1);
    chk("f1_nbytes", wq.size(), 2);
    chk("f1_byte0", {24'd0, wq[0]}, 32'hA5);
    chk("f1_byte1", {24'd0, wq[1]}, 32'h5A);
`ifdef EP6_PKTEND_EN
    chk("f1_pk", pk, 1);
    chk("f1_cnt", cnt(), 0);
`else
    chk("f1_pk", pk, 0);
    chk("f1_cnt", cnt(), 2);
`endif

    // Full 512-byte packet from 256 words
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    wq.delete();
    pk = 0;
    for (int i = 0; i < 256; i++) begin
      send(16'(i), i == 255);
    end
    wait_idle();
    chk("p512_nbytes", wq.size(), 512);
    chk("p512_b0", {24'd0, wq[0]}, 0);
    chk("p512_b3", {24'd0, wq[3]}, 1);
    chk("p512_b510", {24'd0, wq[510]}, 0);
    chk("p512_b511", {24'd0, wq[511]}, 32'hFF);
    chk("p512_pk", pk, 0);
    chk("p512_cnt", cnt(), 0);
    chk("p512_frames", {16'd0, frame_count}, 1);

    // FIFO6_full for 5 cycles in WR_LO
    wq.delete();
    pk = 0;
    send(16'h1234, 1'b0);
    step();
    chk("full_hi_data", {24'd0, FIFO_DATAOUT}, 32'h12);
    step();
    FIFO6_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("full_wr", {31'd0, FIFO_WR}, 0);
      chk("full_oe", {31'd0, FIFO_DATAOUT_OE}, 0);
      chk("full_data", {24'd0, FIFO_DATAOUT}, 32'h34);
      step();
    end
    FIFO6_full = 1'b0;
    #1;
    chk("full_resume_wr", {31'd0, FIFO_WR}, 1);
    chk("full_resume_data", {24'd0, FIFO_DATAOUT}, 32'h34);
    step();
    chk("full_nbytes", wq.size(), 2);
    chk("full_b0", {24'd0, wq[0]}, 32'h12);
    chk("full_b1", {24'd0, wq[1]}, 32'h34);
    chk("full_cnt", cnt(), 2);

    // bus_grant dropped for 3 cycles in WR_HI
    send(16'hBEEF, 1'b0);
    step();
    bus_grant = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("nogrant_oe", {31'd0, FIFO_DATAOUT_OE}, 0);
      chk("nogrant_wr", {31'd0, FIFO_WR}, 0);
      chk("nogrant_busy", {31'd0, busy}, 1);
      step();
    end
    bus_grant = 1'b1;
    #1;
    chk("grant_wr", {31'd0, FIFO_WR}, 1);
    chk("grant_data", {24'd0, FIFO_DATAOUT}, 32'hBE);
    step();
    chk("grant_lo", {24'd0, FIFO_DATAOUT}, 32'hEF);
    step();
    chk("grant_nbytes", wq.size(), 4);
    chk("grant_b2", {24'd0, wq[2]}, 32'hBE);
    chk("grant_b3", {24'd0, wq[3]}, 32'hEF);
    chk("grant_cnt", cnt(), 4);

    // Reset after the high byte
    wq.delete();
    pk = 0;
    send(16'hCAFE, 1'b1);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", {31'd0, FIFO_WR}, 0);
    chk("mid_rst_oe", {31'd0, FIFO_DATAOUT_OE}, 0);
    chk("mid_rst_pktend", {31'd0, FIFO_PKTEND}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ready", {31'd0, s_ready}, 0);
    chk("mid_rst_data", {24'd0, FIFO_DATAOUT}, 0);
    chk("mid_rst_addr", {30'd0, FIFO_FIFOADR}, 0);
    chk("mid_rst_frames", {16'd0, frame_count}, 0);
    chk("mid_rst_cnt", cnt(), 0);
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("mid_rst_nbytes", wq.size(), 1);
    chk("mid_rst_b0", {24'd0, wq[0]}, 32'hCA);
    chk("mid_rst_idle", {31'd0, busy}, 0);
    chk("mid_rst_pk", pk, 0);

    // Three-word frame
    wq.delete();
    pk = 0;
    send(16'h0102, 1'b0);
    send(16'h0304, 1'b0);
    send(16'h0506, 1'b1);
    wait_idle();
    chk("f3_nbytes", wq.size(), 6);
    chk("f3_b0", {24'd0, wq[0]}, 32'h01);
    chk("f3_b5", {24'd0, wq[5]}, 32'h06);
    chk("f3_frames", {16'd0, frame_count}, 1);
`ifdef EP6_PKTEND_EN
    chk("f3_pk", pk, 1);
    chk("f3_cnt", cnt(), 0);
`else
    chk("f3_pk", pk, 0);
    chk("f3_cnt", cnt(), 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
